pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the pc, alu and wdata payload fields.
REQ-002 Parameter RD_W, default 5: width of the destination-register field.
REQ-003 Parameter RESET_PC, default 32'h80000000: out_pc value after reset.
REQ-004 Parameter EXC_RD, default 26: destination register forced on an exception.
REQ-005 Parameter NOWB_PC, default 32'h4: exc_pc value that suppresses the exception writeback.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept; registered, equals !(entry count==2).
REQ-010 in_pc, in_alu, in_wdata  input  DATA_W each  payload.
REQ-011 in_rd  input  RD_W  destination register.
REQ-012 in_regwrite, in_memread, in_memwrite  input  1 each  control bits.
REQ-013 in_memtoreg  input  2  writeback select.
REQ-014 exc_req  input  1  convert the entry being accepted into an exception entry.
REQ-015 exc_pc  input  DATA_W  return address recorded for the exception.
REQ-016 flush  input  1  synchronous kill of all held entries.
REQ-017 out_valid  output  1  head entry present.
REQ-018 out_ready  input  1  downstream consumes the head entry.
REQ-019 out_pc, out_alu, out_wdata, out_rd, out_regwrite, out_memread, out_memwrite, out_memtoreg  output  as the matching inputs  head-entry payload.
REQ-020 stall_cnt, bubble_cnt  output  16 each  performance counters.

Function
REQ-021 The stage SHALL be a 2-entry elastic register (head plus skid) with states EMPTY, ONE and FULL.
REQ-022 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-023 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without pop; ONE->EMPTY on pop without accept; ONE stays ONE on accept with pop; FULL->ONE on pop (no accept is possible in FULL).
REQ-024 Latency SHALL be 1 cycle from accept to out_valid in EMPTY, with full throughput of 1 entry per cycle while out_ready=1.
REQ-025 Entries SHALL leave in order; on a pop in FULL, the skid entry SHALL move to the head in the same edge.
REQ-026 If an accept coincides with exc_req=1, the stored entry SHALL be: rd=EXC_RD, pc=exc_pc, alu=0, wdata=0, memread=0, memwrite=0, memtoreg=2'b11, regwrite=(exc_pc!=NOWB_PC).
REQ-027 exc_req without an accept SHALL be ignored.
REQ-028 flush=1 SHALL set the entry count to 0 at the next edge, and in_ready SHALL be 1 at that edge; flush SHALL take priority over an accept or exc_req in the same cycle.
REQ-029 out_regwrite, out_memread and out_memwrite SHALL read 0 whenever out_valid=0; the other payload outputs SHALL hold their last value.
REQ-030 Payload outputs SHALL be stable while out_valid && !out_ready.

Reset
REQ-031 Reset SHALL force: state EMPTY, out_valid=0, in_ready=1, out_pc=RESET_PC, all other payload outputs 0, and both counters 0.
REQ-032 Reset SHALL take effect immediately and asynchronously; any entries in flight SHALL be discarded.

Configuration
REQ-033 With macro PIPE_STAGE_PERF_CNT_EN defined:
- stall_cnt SHALL increment on each cycle with out_valid && !out_ready.
- bubble_cnt SHALL increment on each cycle with out_valid=0.
- Both counters SHALL saturate at 16'hFFFF and SHALL clear only on reset.
REQ-034 Without PIPE_STAGE_PERF_CNT_EN, stall_cnt and bubble_cnt SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-035 Streaming: in_valid=1 and out_ready=1 for 4 cycles with in_pc=0x100,0x104,0x108,0x10C -> out_pc shows the same sequence one cycle later, in_ready stays 1.
REQ-036 Backpressure: out_ready=0 while pushing 0x200 and 0x204 -> FULL, in_ready=0, out_pc=0x200 held; then out_ready=1 -> out_pc shows 0x200 then 0x204 in order.
REQ-037 Exception: accept with exc_req=1 and exc_pc=0x80000040 -> out_rd=26, out_pc=0x80000040, out_memtoreg=3, out_regwrite=1, out_memwrite=0; repeat with exc_pc=0x4 -> out_regwrite=0.
REQ-038 Flush in FULL with simultaneous in_valid=1 and exc_req=1 -> next cycle out_valid=0, in_ready=1, out_regwrite=0.
REQ-039 Reset asserted mid-stream in FULL -> out_valid=0 and out_pc=0x80000000 immediately, without waiting for a clock edge.
REQ-040 With PIPE_STAGE_PERF_CNT_EN: hold out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF, and it does not wrap.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry elastic pipeline register (head + skid) with exception-entry conversion and flush.
// Define PIPE_STAGE_PERF_CNT_EN to build the saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       RD_W     = 5,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned       EXC_RD   = 26,
  parameter logic [DATA_W-1:0] NOWB_PC  = 32'h0000_0004
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [1:0]        in_memtoreg,
  input  logic              exc_req,
  input  logic [DATA_W-1:0] exc_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic [1:0]        out_memtoreg,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [1:0]        memtoreg;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HEAD_HOLD      = 2'd0,
    HEAD_LOAD_IN   = 2'd1,
    HEAD_LOAD_SKID = 2'd2,
    HEAD_DRAIN     = 2'd3
  } head_op_e;

  localparam entry_t HEAD_RST = {RESET_PC, {(2*DATA_W + RD_W + 5){1'b0}}};
  localparam entry_t SKID_RST = {(3*DATA_W + RD_W + 5){1'b0}};

  // An accepted exception replaces the payload with a trap-return record.
  function automatic entry_t make_entry(input entry_t raw, input logic exc,
                                        input logic [DATA_W-1:0] epc);
    entry_t e;
    if (exc) begin
      e.pc       = epc;
      e.alu      = {DATA_W{1'b0}};
      e.wdata    = {DATA_W{1'b0}};
      e.rd       = RD_W'(EXC_RD);
      e.regwrite = (epc != NOWB_PC);
      e.memread  = 1'b0;
      e.memwrite = 1'b0;
      e.memtoreg = 2'b11;
    end else begin
      e = raw;
    end
    return e;
  endfunction

  function automatic entry_t drop_ctrl(input entry_t e);
    entry_t r;
    r          = e;
    r.regwrite = 1'b0;
    r.memread  = 1'b0;
    r.memwrite = 1'b0;
    return r;
  endfunction

  state_e   state_q, state_d;
  entry_t   head_q, head_d;
  entry_t   skid_q, skid_d;
  entry_t   in_entry_s;
  head_op_e head_op_s;
  logic     skid_load_s;
  logic     in_ready_q, in_ready_d;
  logic     out_valid_q, out_valid_d;
  logic     accept_s, pop_s;

  assign accept_s   = in_valid && in_ready_q;
  assign pop_s      = out_valid_q && out_ready;
  assign in_entry_s = make_entry({in_pc, in_alu, in_wdata, in_rd, in_regwrite,
                                  in_memread, in_memwrite, in_memtoreg},
                                 exc_req, exc_pc);

  // State register plus the registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic; flush overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (accept_s && !pop_s) begin
            state_d = ST_FULL;
          end else if (pop_s && !accept_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL:  state_d = pop_s ? ST_ONE : ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // Output decode: how the head and skid slots move this cycle.
  always_comb begin
    head_op_s   = HEAD_HOLD;
    skid_load_s = 1'b0;
    if (flush) begin
      head_op_s = HEAD_DRAIN;
    end else begin
      case (state_q)
        ST_EMPTY: head_op_s = accept_s ? HEAD_LOAD_IN : HEAD_HOLD;
        ST_ONE: begin
          if (pop_s && accept_s) begin
            head_op_s = HEAD_LOAD_IN;
          end else if (pop_s) begin
            head_op_s = HEAD_DRAIN;
          end else if (accept_s) begin
            skid_load_s = 1'b1;
          end else begin
            head_op_s = HEAD_HOLD;
          end
        end
        ST_FULL:  head_op_s = pop_s ? HEAD_LOAD_SKID : HEAD_HOLD;
        default:  head_op_s = HEAD_DRAIN;
      endcase
    end
  end

  // Slot next values; draining keeps the payload but silences the control bits.
  always_comb begin
    case (head_op_s)
      HEAD_HOLD:      head_d = head_q;
      HEAD_LOAD_IN:   head_d = in_entry_s;
      HEAD_LOAD_SKID: head_d = skid_q;
      HEAD_DRAIN:     head_d = drop_ctrl(head_q);
      default:        head_d = drop_ctrl(head_q);
    endcase
    if (skid_load_s) begin
      skid_d = in_entry_s;
    end else begin
      skid_d = skid_q;
    end
  end

  // Head and skid payload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= HEAD_RST;
      skid_q <= SKID_RST;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = head_q.pc;
  assign out_alu      = head_q.alu;
  assign out_wdata    = head_q.wdata;
  assign out_rd       = head_q.rd;
  assign out_regwrite = head_q.regwrite;
  assign out_memread  = head_q.memread;
  assign out_memwrite = head_q.memwrite;
  assign out_memtoreg = head_q.memtoreg;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] bubble_q, bubble_d;

  // Saturating counter increments; only reset clears them.
  always_comb begin
    if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
    if (!out_valid_q && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end else begin
      bubble_d = bubble_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= 16'h0000;
      bubble_q <= 16'h0000;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = 16'h0000;
  assign bubble_cnt = 16'h0000;
`endif

endmodule
